// File: rtl/cache_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_controller_pkg: shared FSM encoding and address fields, r1.0 |
// +--------------------------------------------------------------------+
package cache_controller_pkg;

    localparam int DEF_INDEX_W  = 6;
    localparam int DEF_TAG_W    = 10;
    localparam int WORD_SEL_BIT = 2;
    localparam int INDEX_LSB    = 3;
    localparam int TAG_LSB      = INDEX_LSB + DEF_INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_MISS = 2'd1,
        ST_WRITE     = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cache_set_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_set_array: 2-way valid/tag/data storage with per-set LRU, r1.0|
// +--------------------------------------------------------------------+
module cache_set_array
    import cache_controller_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               word_sel_i,
    output logic               hit_o,
    output logic               hit_way_o,
    output logic [31:0]        hit_word_o,
    output logic               victim_way_o,
    input  logic               fill_en_i,
    input  logic               fill_way_i,
    input  logic [63:0]        fill_data_i,
    input  logic               word_wr_en_i,
    input  logic               word_wr_way_i,
    input  logic [31:0]        word_wr_data_i,
    input  logic               lru_upd_en_i,
    input  logic               lru_used_way_i
);

    localparam int SETS = 1 << INDEX_W;

    logic [1:0]       valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][2];
    logic [63:0]      data_q  [SETS][2];
    logic [SETS-1:0]  lru_q;

    logic [1:0]  w_match;
    logic [63:0] w_hit_blk;

    always_comb begin
        w_match = '0;
        for (int w = 0; w < 2; w++) begin
            w_match[w] = valid_q[index_i][w] && (tag_q[index_i][w] == tag_i);
        end
    end

    assign hit_o      = |w_match;
    assign hit_way_o  = w_match[1];
    assign w_hit_blk  = data_q[index_i][hit_way_o];
    assign hit_word_o = word_sel_i ? w_hit_blk[63:32] : w_hit_blk[31:0];

    // Empty ways are filled before any valid line is evicted.
    assign victim_way_o = !valid_q[index_i][0] ? 1'b0 :
                          !valid_q[index_i][1] ? 1'b1 : lru_q[index_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (fill_en_i) begin
                valid_q[index_i][fill_way_i] <= 1'b1;
            end
            if (lru_upd_en_i) begin
                lru_q[index_i] <= ~lru_used_way_i;
            end
        end
    end

    // Tag/data need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[index_i][fill_way_i]  <= tag_i;
            data_q[index_i][fill_way_i] <= fill_data_i;
        end else if (word_wr_en_i) begin
            if (word_sel_i) begin
                data_q[index_i][word_wr_way_i][63:32] <= word_wr_data_i;
            end else begin
                data_q[index_i][word_wr_way_i][31:0] <= word_wr_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_controller: 2-way write-through no-allocate D-cache FSM, r1.0|
// +--------------------------------------------------------------------+
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_Data,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int TAG_LO = TAG_LSB - DEF_INDEX_W + INDEX_W;

    state_e state_q, state_d;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_word_sel;
    logic               w_req;
    logic               w_hit;
    logic               w_hit_way;
    logic [31:0]        w_hit_word;
    logic               w_victim_way;
    logic [31:0]        w_fill_word;
    logic               w_fill_en;
    logic               w_word_wr_en;
    logic               w_lru_upd_en;
    logic               w_lru_used_way;

    assign w_index     = address[INDEX_LSB +: INDEX_W];
    assign w_tag       = address[TAG_LO +: TAG_W];
    assign w_word_sel  = address[WORD_SEL_BIT];
    assign w_req       = rd_en | wr_en;
    assign w_fill_word = w_word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

    assign sram_address = address;
    assign sram_wdata   = write_Data;
    assign sram_rd_en   = (state_q == ST_READ_MISS);
    assign sram_wr_en   = (state_q == ST_WRITE);

    cache_set_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_set_array (
        .clk            (clk),
        .rst            (rst),
        .index_i        (w_index),
        .tag_i          (w_tag),
        .word_sel_i     (w_word_sel),
        .hit_o          (w_hit),
        .hit_way_o      (w_hit_way),
        .hit_word_o     (w_hit_word),
        .victim_way_o   (w_victim_way),
        .fill_en_i      (w_fill_en),
        .fill_way_i     (w_victim_way),
        .fill_data_i    (sram_rdata),
        .word_wr_en_i   (w_word_wr_en),
        .word_wr_way_i  (w_hit_way),
        .word_wr_data_i (write_Data),
        .lru_upd_en_i   (w_lru_upd_en),
        .lru_used_way_i (w_lru_used_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ready          = 1'b0;
        rdata          = '0;
        w_fill_en      = 1'b0;
        w_word_wr_en   = 1'b0;
        w_lru_upd_en   = 1'b0;
        w_lru_used_way = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    state_d = ST_WRITE;
                end else if (rd_en) begin
                    if (w_hit) begin
                        ready          = 1'b1;
                        rdata          = w_hit_word;
                        w_lru_upd_en   = 1'b1;
                        w_lru_used_way = w_hit_way;
                    end else begin
                        state_d = ST_READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            ST_READ_MISS: begin
                if (!w_req) begin
                    state_d = ST_IDLE;
                end else if (sram_ready) begin
                    // Returned block is bypassed to rdata while it is written.
                    ready          = 1'b1;
                    rdata          = w_fill_word;
                    w_fill_en      = 1'b1;
                    w_lru_upd_en   = 1'b1;
                    w_lru_used_way = w_victim_way;
                    state_d        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!w_req) begin
                    state_d = ST_IDLE;
                end else if (sram_ready) begin
                    ready = 1'b1;
                    if (w_hit) begin
                        w_word_wr_en   = 1'b1;
                        w_lru_upd_en   = 1'b1;
                        w_lru_used_way = w_hit_way;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
